// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Arbitrates the single-ported, byte-wide unified memory between instruction
// fetch and the data stage. Each granted word moves as four big-endian byte
// beats. Read data is assembled and returned with a one-cycle done pulse.
// Data requests have priority. A starvation counter hands a tie to fetch
// after STARVE_MAX consecutive data grants.
//
// Ports:
//   clock, reset_n            rising-edge clock, async active-low reset
//   if_req/if_addr            fetch word-read request (held until if_done)
//   if_rdata/if_done          fetched word and completion pulse
//   dm_req/dm_we/dm_addr/     data read/write request (held until dm_done)
//   dm_wdata
//   dm_rdata/dm_done          load data and completion pulse
//   mem_en/mem_we/mem_addr/   per-beat memory interface; read data arrives
//   mem_wdata/mem_rdata       the cycle after its beat
//   busy                      transfer in progress
//   owner                     current or last grantee (1 = data, 0 = fetch)
module mem_port_arbiter #(
    parameter int unsigned STARVE_MAX = 3,
    parameter int unsigned ADDR_W     = 12
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_done,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [31:0]       dm_wdata,
    output logic [31:0]       dm_rdata,
    output logic              dm_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              owner
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned BEAT_W = 2;
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              state,      state_nxt;
    logic [BEAT_W-1:0]   beat,       beat_nxt;
    logic [ADDR_W-1:0]   base,       base_nxt;
    logic                we_l,       we_l_nxt;
    logic [31:0]         wdata_l,    wdata_l_nxt;
    logic [CNT_W-1:0]    starve_cnt, starve_cnt_nxt;
    logic [23:0]         rd_buf,     rd_buf_nxt;
    logic                owner_nxt;
    logic [31:0]         if_rdata_nxt, dm_rdata_nxt;
    logic                if_done_nxt,  dm_done_nxt;
    logic                mem_en_nxt,   mem_we_nxt;
    logic [ADDR_W-1:0]   mem_addr_nxt;
    logic [7:0]          mem_wdata_nxt;
    logic                busy_nxt;

    logic                grant_dm_c;
    logic                grant_if_c;

    // Big-endian byte select: beat 0 carries the most significant byte.
    function automatic logic [7:0] beat_byte(input logic [31:0] w,
                                             input logic [BEAT_W-1:0] b);
        logic [7:0] r;
        case (b)
            2'd0:    r = w[31:24];
            2'd1:    r = w[23:16];
            2'd2:    r = w[15:8];
            default: r = w[7:0];
        endcase
        return r;
    endfunction

    // Tie goes to data unless fetch has waited through STARVE_MAX data grants.
    always_comb begin
        grant_dm_c = dm_req && !(if_req && (starve_cnt == STARVE_LIM));
        grant_if_c = if_req && !grant_dm_c;
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_nxt      = state;
        beat_nxt       = beat;
        base_nxt       = base;
        we_l_nxt       = we_l;
        wdata_l_nxt    = wdata_l;
        starve_cnt_nxt = starve_cnt;
        rd_buf_nxt     = rd_buf;
        owner_nxt      = owner;
        if_rdata_nxt   = if_rdata;
        dm_rdata_nxt   = dm_rdata;
        if_done_nxt    = 1'b0;
        dm_done_nxt    = 1'b0;
        mem_en_nxt     = 1'b0;
        mem_we_nxt     = 1'b0;
        mem_addr_nxt   = '0;
        mem_wdata_nxt  = '0;

        case (state)
            S_IDLE: begin
                if (grant_dm_c || grant_if_c) begin
                    state_nxt   = S_XFER;
                    beat_nxt    = '0;
                    owner_nxt   = grant_dm_c;
                    base_nxt    = grant_dm_c ? dm_addr : if_addr;
                    we_l_nxt    = grant_dm_c && dm_we;
                    wdata_l_nxt = grant_dm_c ? dm_wdata : 32'd0;
                    if (grant_if_c) begin
                        starve_cnt_nxt = '0;
                    end else if (if_req && (starve_cnt != STARVE_LIM)) begin
                        starve_cnt_nxt = starve_cnt + CNT_W'(1);
                    end
                    // Beat 0 is presented in the first XFER cycle.
                    mem_en_nxt    = 1'b1;
                    mem_we_nxt    = we_l_nxt;
                    mem_addr_nxt  = base_nxt;
                    mem_wdata_nxt = beat_byte(wdata_l_nxt, 2'd0);
                end
            end
            S_XFER: begin
                // Byte from the previous beat is valid now.
                case (beat)
                    2'd1:    rd_buf_nxt[23:16] = mem_rdata;
                    2'd2:    rd_buf_nxt[15:8]  = mem_rdata;
                    2'd3:    rd_buf_nxt[7:0]   = mem_rdata;
                    default: rd_buf_nxt        = rd_buf;
                endcase
                if (beat == 2'd3) begin
                    state_nxt = S_WAIT;
                end else begin
                    beat_nxt      = beat + BEAT_W'(1);
                    mem_en_nxt    = 1'b1;
                    mem_we_nxt    = we_l;
                    mem_addr_nxt  = base + ADDR_W'(beat_nxt);
                    mem_wdata_nxt = beat_byte(wdata_l, beat_nxt);
                end
            end
            S_WAIT: begin
                // Last byte lands here; done and rdata update appear in DONE.
                state_nxt = S_DONE;
                if (owner) begin
                    dm_done_nxt = 1'b1;
                    if (!we_l) begin
                        dm_rdata_nxt = {rd_buf, mem_rdata};
                    end
                end else begin
                    if_done_nxt  = 1'b1;
                    if_rdata_nxt = {rd_buf, mem_rdata};
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        busy_nxt = (state_nxt != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            beat       <= '0;
            base       <= '0;
            we_l       <= 1'b0;
            wdata_l    <= '0;
            starve_cnt <= '0;
            rd_buf     <= '0;
            owner      <= 1'b0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
            if_done    <= 1'b0;
            dm_done    <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            beat       <= beat_nxt;
            base       <= base_nxt;
            we_l       <= we_l_nxt;
            wdata_l    <= wdata_l_nxt;
            starve_cnt <= starve_cnt_nxt;
            rd_buf     <= rd_buf_nxt;
            owner      <= owner_nxt;
            if_rdata   <= if_rdata_nxt;
            dm_rdata   <= dm_rdata_nxt;
            if_done    <= if_done_nxt;
            dm_done    <= dm_done_nxt;
            mem_en     <= mem_en_nxt;
            mem_we     <= mem_we_nxt;
            mem_addr   <= mem_addr_nxt;
            mem_wdata  <= mem_wdata_nxt;
            busy       <= busy_nxt;
        end
    end

endmodule
